spi_word_receiver: RTL and testbench

Parametrised SPI slave receiver. It oversamples SCLK, nCS and SDI in the system clock domain and supports all four SPI modes. It assembles words of configurable width, both MSB- and LSB-first, and frames may carry any number of back-to-back words. Completed words are buffered in a small FIFO and presented on a valid/ready stream to the image-pixel ingest logic. Overrun and partial-word errors are flagged.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/spi_word_receiver.sv | 193 +++++++++++++++++++
 tb/tb_spi_word_receiver.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI word receiver.
//   spi_rx_state_t : receiver FSM states
//   sample_on_rise : 1 when the SPI mode samples SDI on the rising SCLK edge
//   cnt_width      : bit-counter width for a given word width
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_rx_state_t;

  // Modes 0 and 3 sample on rising SCLK; modes 1 and 2 on falling SCLK.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned word_bits);
    return $clog2(word_bits);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head (rd_data/rd_valid are flops).
//   clk, nreset        : clock, async active-low reset
//   wr_valid/wr_data   : push request and payload
//   wr_ready_c         : push will be accepted this cycle (combinational)
//   rd_valid/rd_data   : FIFO non-empty and head entry
//   rd_ready           : consumer pops head when rd_valid && rd_ready
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready_c,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_n, rd_ptr_n;
  logic [WIDTH-1:0] head_n;
  logic             full_c, pop_c, push_c;

  // Pointer bookkeeping; a pop in the same cycle frees a slot for the push.
  always_comb begin
    full_c     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop_c      = rd_valid & rd_ready;
    wr_ready_c = ~full_c | pop_c;
    push_c     = wr_valid & wr_ready_c;
    wr_ptr_n   = wr_ptr + PW'(push_c);
    rd_ptr_n   = rd_ptr + PW'(pop_c);
    // A word written into an otherwise empty FIFO becomes the next head.
    if (push_c && (wr_ptr == rd_ptr_n)) begin
      head_n = wr_data;
    end else begin
      head_n = mem[rd_ptr_n[AW-1:0]];
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointers and registered head
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      rd_valid <= (wr_ptr_n != rd_ptr_n);
      if (wr_ptr_n != rd_ptr_n) begin
        rd_data <= head_n;
      end
    end
  end

endmodule

// File: rtl/spi_word_receiver.sv
// SPI slave receiver: oversamples sclk/ncs/sdi, assembles WORD_BITS words in
// any SPI mode and bit order, and streams them out through a small FIFO.
//   clk, nreset       : system clock (>= 4x SCLK), async active-low reset
//   sclk, ncs, sdi    : asynchronous SPI pins
//   m_data/m_sof      : head word and first-word-of-frame flag
//   m_valid/m_ready   : output stream handshake
//   frame_active      : synchronised nCS is low
//   partial_err       : one-cycle pulse when a frame ends mid-word
//   overrun           : sticky, a completed word was dropped (FIFO full)
//   overrun_clr       : clears overrun
module spi_word_receiver
  import spi_pkg::*;
#(
  parameter int unsigned WORD_BITS   = 8,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 sclk,
  input  logic                 ncs,
  input  logic                 sdi,
  output logic [WORD_BITS-1:0] m_data,
  output logic                 m_sof,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_active,
  output logic                 partial_err,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int unsigned CNT_W       = cnt_width(WORD_BITS);
  localparam int unsigned LAST        = SYNC_STAGES - 1;
  localparam logic        SAMPLE_RISE = sample_on_rise(1'(CPOL), 1'(CPHA));
  localparam logic        SCLK_IDLE   = 1'(CPOL);

  logic [SYNC_STAGES-1:0] sclk_s, ncs_s, sdi_s;
  logic                   sclk_d, ncs_d;
  logic                   sample_c, ncs_fall_c, ncs_rise_c;

  spi_rx_state_t          state, state_n;
  logic [WORD_BITS-1:0]   shreg, shreg_n, shifted_c;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic                   first_word, first_word_n;
  logic                   push, push_n;
  logic [WORD_BITS:0]     push_data, push_data_n;
  logic                   partial_err_n;
  logic                   fifo_ready_c;
  logic [WORD_BITS:0]     fifo_head;

  // Input synchronisers plus one extra flop on sclk/ncs for edge detection
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sclk_s <= {SYNC_STAGES{SCLK_IDLE}};
      ncs_s  <= '1;
      sdi_s  <= '0;
      sclk_d <= SCLK_IDLE;
      ncs_d  <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      ncs_s  <= {ncs_s[SYNC_STAGES-2:0], ncs};
      sdi_s  <= {sdi_s[SYNC_STAGES-2:0], sdi};
      sclk_d <= sclk_s[LAST];
      ncs_d  <= ncs_s[LAST];
    end
  end

  // Edge detection from the last synchroniser stage
  always_comb begin
    if (SAMPLE_RISE) begin
      sample_c = sclk_s[LAST] & ~sclk_d;
    end else begin
      sample_c = ~sclk_s[LAST] & sclk_d;
    end
    ncs_fall_c = ~ncs_s[LAST] & ncs_d;
    ncs_rise_c = ncs_s[LAST] & ~ncs_d;
  end

  // Shift register with the new SDI bit inserted per bit order
  always_comb begin
    if (MSB_FIRST != 0) begin
      shifted_c = {shreg[WORD_BITS-2:0], sdi_s[LAST]};
    end else begin
      shifted_c = {sdi_s[LAST], shreg[WORD_BITS-1:1]};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ncs_fall_c) state_n = SHIFT;
      SHIFT:   if (ncs_rise_c) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM outputs / datapath next values
  always_comb begin
    shreg_n       = shreg;
    cnt_n         = cnt;
    first_word_n  = first_word;
    push_n        = 1'b0;
    push_data_n   = push_data;
    partial_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (ncs_fall_c) begin
          shreg_n      = '0;
          cnt_n        = '0;
          first_word_n = 1'b1;
        end
      end
      SHIFT: begin
        if (sample_c) begin
          shreg_n = shifted_c;
          if (cnt == CNT_W'(WORD_BITS - 1)) begin
            push_n       = 1'b1;
            push_data_n  = {first_word, shifted_c};
            cnt_n        = '0;
            first_word_n = 1'b0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        // Evaluated after the sample so a word completing with nCS rise is kept.
        if (ncs_rise_c) begin
          if (cnt_n != '0) begin
            partial_err_n = 1'b1;
          end
          cnt_n = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shreg        <= '0;
      cnt          <= '0;
      first_word   <= 1'b0;
      push         <= 1'b0;
      push_data    <= '0;
      partial_err  <= 1'b0;
      overrun      <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      shreg        <= shreg_n;
      cnt          <= cnt_n;
      first_word   <= first_word_n;
      push         <= push_n;
      push_data    <= push_data_n;
      partial_err  <= partial_err_n;
      // A new drop wins over a simultaneous clear.
      overrun      <= (push & ~fifo_ready_c) | (overrun & ~overrun_clr);
      // Tracks ~ncs_s[LAST] without an extra cycle of delay.
      frame_active <= ~ncs_s[SYNC_STAGES-2];
    end
  end

  sync_fifo #(
    .WIDTH (WORD_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .nreset     (nreset),
    .wr_valid   (push),
    .wr_data    (push_data),
    .wr_ready_c (fifo_ready_c),
    .rd_valid   (m_valid),
    .rd_data    (fifo_head),
    .rd_ready   (m_ready)
  );

  assign m_data = fifo_head[WORD_BITS-1:0];
  assign m_sof  = fifo_head[WORD_BITS];

endmodule

// File: tb/tb_spi_word_receiver.sv
`timescale 1ns/1ps
// Bench for spi_word_receiver: three instances (mode 0 MSB-first, mode 3
// MSB-first, mode 1 LSB-first) driven by a behavioural SPI master.
module tb_spi_word_receiver;

  localparam int W    = 8;
  localparam int HALF = 40;
  localparam int SYNC = 2;

  logic       clk;
  logic       nreset;
  logic [2:0] sclk, ncs, sdi, m_ready, overrun_clr;
  logic [2:0] m_sof, m_valid, frame_active, partial_err, overrun;
  logic [7:0] m_data [3];
  logic [2:0] ready_force, ready_rand;

  int         checks   = 0;
  int         failures = 0;
  logic [8:0] got [3][$];
  logic [8:0] expq [$];
  int         perr_cnt [3];
  time        t_sclk0, t_valid0;
  logic [255:0] bv;
  int           nb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_word_receiver #(.WORD_BITS(W), .CPOL(0), .CPHA(0), .MSB_FIRST(1),
                      .SYNC_STAGES(SYNC), .FIFO_DEPTH(4)) u_mode0 (
    .clk(clk), .nreset(nreset), .sclk(sclk[0]), .ncs(ncs[0]), .sdi(sdi[0]),
    .m_data(m_data[0]), .m_sof(m_sof[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .frame_active(frame_active[0]), .partial_err(partial_err[0]),
    .overrun(overrun[0]), .overrun_clr(overrun_clr[0]));

  spi_word_receiver #(.WORD_BITS(W), .CPOL(1), .CPHA(1), .MSB_FIRST(1),
                      .SYNC_STAGES(SYNC), .FIFO_DEPTH(4)) u_mode3 (
    .clk(clk), .nreset(nreset), .sclk(sclk[1]), .ncs(ncs[1]), .sdi(sdi[1]),
    .m_data(m_data[1]), .m_sof(m_sof[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .frame_active(frame_active[1]), .partial_err(partial_err[1]),
    .overrun(overrun[1]), .overrun_clr(overrun_clr[1]));

  spi_word_receiver #(.WORD_BITS(W), .CPOL(0), .CPHA(1), .MSB_FIRST(0),
                      .SYNC_STAGES(SYNC), .FIFO_DEPTH(4)) u_mode1_lsb (
    .clk(clk), .nreset(nreset), .sclk(sclk[2]), .ncs(ncs[2]), .sdi(sdi[2]),
    .m_data(m_data[2]), .m_sof(m_sof[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]),
    .frame_active(frame_active[2]), .partial_err(partial_err[2]),
    .overrun(overrun[2]), .overrun_clr(overrun_clr[2]));

  function automatic logic cpol_of(input int i); return (i == 1); endfunction
  function automatic logic cpha_of(input int i); return (i != 0); endfunction
  function automatic logic msb_of(input int i);  return (i != 2); endfunction

  // Consumer ready: forced level or random per cycle.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 3; i++)
      m_ready[i] = ready_rand[i] ? 1'($urandom_range(0, 1)) : ready_force[i];
  end

  // Collect accepted beats and partial_err pulses.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_valid[i] && m_ready[i]) got[i].push_back({m_sof[i], m_data[i]});
      if (partial_err[i]) perr_cnt[i] <= perr_cnt[i] + 1;
    end
  end

  always @(posedge sclk[0])    t_sclk0  <= $time;
  always @(posedge m_valid[0]) t_valid0 <= $time;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Append a word to the bit stream in the wire order of instance idx.
  task automatic add_word(input int idx, input logic [7:0] w);
    for (int k = 0; k < W; k++) begin
      bv[nb] = msb_of(idx) ? w[W-1-k] : w[k];
      nb++;
    end
  endtask

  // SPI master: drives nb bits of bv on instance idx in its SPI mode.
  task automatic send_bits(input int idx, input bit end_frame);
    logic pol;
    pol = cpol_of(idx);
    @(negedge clk);
    sclk[idx] = pol;
    ncs[idx]  = 1'b0;
    #(HALF);
    for (int k = 0; k < nb; k++) begin
      if (!cpha_of(idx)) begin
        sdi[idx] = bv[k];
        #(HALF); sclk[idx] = ~pol;
        #(HALF); sclk[idx] = pol;
      end else begin
        sclk[idx] = ~pol;
        sdi[idx]  = bv[k];
        #(HALF); sclk[idx] = pol;
        #(HALF);
      end
    end
    if (end_frame) begin
      #(HALF); ncs[idx] = 1'b1;
      #(HALF);
    end
    nb = 0;
  endtask

  task automatic check_beats(input int idx, input int base, input string tag);
    chk({tag, "_count"}, 32'(got[idx].size() - base), 32'(expq.size()));
    for (int k = 0; k < expq.size(); k++)
      if (base + k < got[idx].size())
        chk($sformatf("%s_beat%0d", tag, k), 32'(got[idx][base+k]), 32'(expq[k]));
  endtask

  initial begin
    int base, p, nw, tail, idx;
    logic [7:0] v;
    nb          = 0;
    bv          = '0;
    nreset      = 1'b0;
    ncs         = 3'b111;
    sclk        = 3'b010;
    sdi         = 3'b000;
    overrun_clr = 3'b000;
    ready_force = 3'b000;
    ready_rand  = 3'b000;
    for (int i = 0; i < 3; i++) perr_cnt[i] = 0;

    // Reset state
    wait_clks(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_valid%0d", i),   32'(m_valid[i]), 0);
      chk($sformatf("rst_sof%0d", i),     32'(m_sof[i]), 0);
      chk($sformatf("rst_data%0d", i),    32'(m_data[i]), 0);
      chk($sformatf("rst_active%0d", i),  32'(frame_active[i]), 0);
      chk($sformatf("rst_overrun%0d", i), 32'(overrun[i]), 0);
      chk($sformatf("rst_perr%0d", i),    32'(partial_err[i]), 0);
    end
    nreset      = 1'b1;
    ready_force = 3'b111;
    wait_clks(5);

    // Mode 0, single word 0xA5, plus output latency
    base = got[0].size(); p = perr_cnt[0];
    add_word(0, 8'hA5);
    send_bits(0, 1'b1);
    wait_clks(20);
    expq = {9'h1A5};
    check_beats(0, base, "m0_a5");
    chk("m0_a5_perr", 32'(perr_cnt[0] - p), 0);
    chk("m0_latency_ns", 32'(t_valid0 - t_sclk0), 32'((SYNC + 2) * 10 - 5));

    // Mode 3, three words in one frame
    base = got[1].size(); p = perr_cnt[1];
    add_word(1, 8'h12); add_word(1, 8'h34); add_word(1, 8'h56);
    send_bits(1, 1'b1);
    wait_clks(20);
    expq = {9'h112, 9'h034, 9'h056};
    check_beats(1, base, "m3_three");
    chk("m3_three_perr", 32'(perr_cnt[1] - p), 0);

    // Mode 1, LSB-first 0xA5
    base = got[2].size(); p = perr_cnt[2];
    add_word(2, 8'hA5);
    send_bits(2, 1'b1);
    wait_clks(20);
    expq = {9'h1A5};
    check_beats(2, base, "m1_lsb");
    chk("m1_lsb_perr", 32'(perr_cnt[2] - p), 0);

    // Five-bit frame: partial error, nothing delivered
    base = got[0].size(); p = perr_cnt[0];
    add_word(0, 8'hC3); nb = 5;
    send_bits(0, 1'b1);
    wait_clks(20);
    chk("partial_pulse", 32'(perr_cnt[0] - p), 1);
    chk("partial_nobeat", 32'(got[0].size() - base), 0);
    chk("partial_valid", 32'(m_valid[0]), 0);

    // Overrun: six words into a 4-deep FIFO with the consumer stalled
    ready_force[0] = 1'b0;
    wait_clks(3);
    base = got[0].size();
    add_word(0, 8'h11); add_word(0, 8'h22); add_word(0, 8'h33);
    add_word(0, 8'h44); add_word(0, 8'h55); add_word(0, 8'h66);
    send_bits(0, 1'b1);
    wait_clks(20);
    chk("ovr_flag", 32'(overrun[0]), 1);
    chk("ovr_valid", 32'(m_valid[0]), 1);
    chk("ovr_head", 32'(m_data[0]), 32'h11);
    chk("ovr_head_sof", 32'(m_sof[0]), 1);
    @(negedge clk); overrun_clr[0] = 1'b1;
    @(negedge clk); overrun_clr[0] = 1'b0;
    wait_clks(3);
    chk("ovr_cleared", 32'(overrun[0]), 0);
    chk("ovr_head_stable", 32'(m_data[0]), 32'h11);
    ready_force[0] = 1'b1;
    wait_clks(20);
    expq = {9'h111, 9'h022, 9'h033, 9'h044};
    check_beats(0, base, "ovr_drain");
    chk("ovr_after_drain", 32'(overrun[0]), 0);

    // Reset mid-word, then a clean 0x3C frame
    base = got[0].size(); p = perr_cnt[0];
    add_word(0, 8'hFF); nb = 4;
    send_bits(0, 1'b0);
    wait_clks(2);
    chk("midword_active", 32'(frame_active[0]), 1);
    nreset = 1'b0;
    #20;
    ncs[0]  = 1'b1;
    sclk[0] = 1'b0;
    #20;
    nreset = 1'b1;
    wait_clks(5);
    chk("postrst_active", 32'(frame_active[0]), 0);
    chk("postrst_valid", 32'(m_valid[0]), 0);
    add_word(0, 8'h3C);
    send_bits(0, 1'b1);
    wait_clks(20);
    expq = {9'h13C};
    check_beats(0, base, "rst_3c");
    chk("rst_3c_perr", 32'(perr_cnt[0] - p), 0);

    // Random frames on all three instances with a random consumer
    ready_rand = 3'b111;
    for (int f = 0; f < 9; f++) begin
      idx  = f % 3;
      nw   = $urandom_range(1, 3);
      tail = ($urandom_range(0, 2) == 0) ? $urandom_range(1, W - 1) : 0;
      base = got[idx].size(); p = perr_cnt[idx];
      expq.delete();
      for (int w = 0; w < nw; w++) begin
        v = 8'($urandom);
        add_word(idx, v);
        expq.push_back({(w == 0), v});
      end
      for (int t = 0; t < tail; t++) begin
        bv[nb] = 1'($urandom);
        nb++;
      end
      send_bits(idx, 1'b1);
      wait_clks(40);
      check_beats(idx, base, $sformatf("rnd%0d", f));
      chk($sformatf("rnd%0d_perr", f), 32'(perr_cnt[idx] - p), 32'(tail != 0));
      chk($sformatf("rnd%0d_overrun", f), 32'(overrun[idx]), 0);
    end
    ready_rand = 3'b000;
    wait_clks(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
